hd_onehot_pos_encoder: RTL and testbench
========================================

# hd_onehot_pos_encoder

Downstream consumer of the 8-bit isolate-rightmost-zero kernel. It accepts that kernel's result words over a valid/ready handshake and encodes each one as a bit position with zero/error flags. Results pass through a 2-entry output FIFO. It also keeps saturating statistics counters. It turns the kernel's one-hot-or-zero mask into an index usable by later arithmetic stages.

## Interface
- W, default 8: input word width; must be a power of two ≥ 2.
- PW, default $clog2(W): position field width (derived; not overridable).
- CNT_W, default 16: statistics counter width.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream word present
- in_ready  out  1  block can accept a word this cycle
- in_data  in  W  kernel result (expected one-hot or zero)
- out_valid  out  1  head FIFO entry valid
- out_ready  in  1  downstream accepts head entry
- out_pos  out  PW  index of lowest set bit of the word (0 if word is zero)
- out_zero  out  1  word was all-zero
- out_err  out  1  word had more than one bit set
- stat_words  out  CNT_W  count of accepted words, saturating
- stat_errs  out  CNT_W  count of accepted words with err set, saturating

## Operation
- Accept: in_valid & in_ready. Pop: out_valid & out_ready.
- Encode on accept, combinationally from in_data:
  - pos = lowest set index.
  - zero = (in_data == 0).
  - err = popcount(in_data) ≥ 2.
  - When zero = 1: pos = 0 and err = 0.
- FIFO: 2 entries {pos, zero, err}; 2-bit occupancy `occ` ∈ {0,1,2}; read/write pointers wrap modulo 2.
- State by occupancy:
  - EMPTY (occ=0): accept only → occ 1.
  - ONE (occ=1):
    - accept & pop → stays 1; new entry becomes head next cycle.
    - accept only → 2.
    - pop only → 0.
  - FULL (occ=2): in_ready=0; pop → 1. An offered word is ignored (not accepted) and must be held by upstream.
- Handshake rules:
  - in_ready = (occ != 2), registered-derived only; no combinational path from out_ready.
  - out_valid = (occ != 0).
  - out_pos, out_zero, out_err show the head entry and are stable while out_valid & !out_ready.
- Statistics:
  - stat_words increments by 1 per accept.
  - stat_errs increments per accept with err=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Reset (rst high at edge): occ=0, pointers=0, and FIFO contents cleared to 0. Any in-flight word is discarded, including mid-stall and when full.
- While rst is high, in_ready=0 and no accept occurs regardless of in_valid.

## Timing
- Reset values on the cycle after rst is sampled high:
  - out_valid=0, out_pos=0, out_zero=0, out_err=0.
  - stat_words=0, stat_errs=0.
  - in_ready=0 while rst is held; in_ready=1 on the first cycle after rst deasserts.
- Latency: a word accepted at edge N is visible on out_* with out_valid=1 after edge N when the FIFO was empty (1 cycle).
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Counters update at the same edge as the accept; the new value is visible the following cycle.
- Backpressure: at most 2 words are buffered. in_ready drops the cycle after the second unpopped accept. It rises the cycle after a pop from FULL.

## Test plan
- Reset then idle: hold rst 3 cycles, release → out_valid=0, in_ready=1, stats=0.
- Streaming with out_ready=1: feed 8'h01, 8'h08, 8'h80, 8'h00 → out_pos 0, 3, 7, 0 on consecutive cycles, 1 cycle after each accept. Last word has out_zero=1. stat_words=4, stat_errs=0.
- Error encoding: feed 8'h0C → out_pos=2, out_err=1, out_zero=0, stat_errs=1. Feed 8'hFF → pos=0, err=1.
- Backpressure: out_ready=0, offer 8'h02, 8'h04, 8'h10 → only the first two are accepted and in_ready=0 after 2 accepts. Raise out_ready → outputs 1, 2, 4 in order, with out_* stable during the stall.
- Simultaneous accept+pop at occ=1: hold occ at 1 and stream 8'h20, 8'h40 with out_ready=1 → occ stays 1 and order is preserved.
- Reset mid-operation and saturation:
  - Assert rst with FIFO full → next cycle out_valid=0 and stats=0.
  - With CNT_W=2, accept 5 words incl. 4 errors → stat_words=3, stat_errs=3 (no wrap).

Source files
------------

// File: rtl/hd_onehot_pos_encoder.sv
// Encodes one-hot-or-zero kernel words into a bit position plus zero/error flags,
// buffered through a 2-entry FIFO, with saturating word/error counters.
module hd_onehot_pos_encoder #(
    parameter int W = 8,
    parameter int CNT_W = 16,
    localparam int PW = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_pos,
    output logic             out_zero,
    output logic             out_err,
    output logic [CNT_W-1:0] stat_words,
    output logic [CNT_W-1:0] stat_errs
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    localparam logic [W-1:0]     ONE_W   = W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Mask of word indices whose binary index has bit b set.
    function automatic logic [W-1:0] pos_mask(input int b);
        logic [W-1:0] m;
        for (int j = 0; j < W; j++) begin
            m[j] = ((j >> b) & 1) == 1;
        end
        return m;
    endfunction

    occ_t            occ_reg;
    occ_t            occ_next;
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [PW-1:0]   mem_pos_reg  [2];
    logic            mem_zero_reg [2];
    logic            mem_err_reg  [2];
    logic [CNT_W-1:0] stat_words_reg;
    logic [CNT_W-1:0] stat_errs_reg;

    logic            accept;
    logic            pop;
    logic [W-1:0]    iso;
    logic [PW-1:0]   enc_pos;
    logic            enc_zero;
    logic            enc_err;

    // Isolating the lowest set bit makes the position a plain OR-encode.
    assign iso      = in_data & (~in_data + ONE_W);
    assign enc_zero = ~|in_data;
    assign enc_err  = |(in_data & (in_data - ONE_W));

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_pos
            localparam logic [W-1:0] SEL = pos_mask(gi);
            assign enc_pos[gi] = |(iso & SEL);
        end
    endgenerate

    assign in_ready  = !rst && (occ_reg != OCC_FULL);
    assign out_valid = (occ_reg != OCC_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_pos    = mem_pos_reg[rd_ptr_reg];
    assign out_zero   = mem_zero_reg[rd_ptr_reg];
    assign out_err    = mem_err_reg[rd_ptr_reg];
    assign stat_words = stat_words_reg;
    assign stat_errs  = stat_errs_reg;

    always_comb begin
        occ_next = occ_reg;
        case (occ_reg)
            OCC_EMPTY: if (accept) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (accept && !pop) occ_next = OCC_FULL;
                else if (!accept && pop) occ_next = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg        <= OCC_EMPTY;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            stat_words_reg <= '0;
            stat_errs_reg  <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_pos_reg[i]  <= '0;
                mem_zero_reg[i] <= 1'b0;
                mem_err_reg[i]  <= 1'b0;
            end
        end else begin
            occ_reg <= occ_next;
            if (accept) begin
                mem_pos_reg[wr_ptr_reg]  <= enc_pos;
                mem_zero_reg[wr_ptr_reg] <= enc_zero;
                mem_err_reg[wr_ptr_reg]  <= enc_err;
                wr_ptr_reg               <= ~wr_ptr_reg;
                if (stat_words_reg != CNT_MAX) stat_words_reg <= stat_words_reg + CNT_ONE;
                if (enc_err && stat_errs_reg != CNT_MAX) stat_errs_reg <= stat_errs_reg + CNT_ONE;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

endmodule

// File: tb/tb_hd_onehot_pos_encoder.sv
// Directed bench for hd_onehot_pos_encoder: encoding table, backpressure,
// accept+pop at occupancy one, reset while full, and counter saturation.
module tb_hd_onehot_pos_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready, out_valid, out_zero, out_err;
    logic [2:0] out_pos;
    logic [15:0] stat_words, stat_errs;
    logic       s_in_ready, s_out_valid, s_out_zero, s_out_err;
    logic [2:0] s_out_pos;
    logic [1:0] s_stat_words, s_stat_errs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hd_onehot_pos_encoder #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pos(out_pos), .out_zero(out_zero), .out_err(out_err),
        .stat_words(stat_words), .stat_errs(stat_errs)
    );

    hd_onehot_pos_encoder #(.W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pos(s_out_pos), .out_zero(s_out_zero), .out_err(s_out_err),
        .stat_words(s_stat_words), .stat_errs(s_stat_errs)
    );

    typedef struct {
        logic [7:0] data;
        int         pos;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input int pos, input logic z, input logic e);
        chk({tag, " valid"}, 32'(out_valid), 1);
        chk({tag, " pos"},   32'(out_pos), pos);
        chk({tag, " zero"},  32'(out_zero), 32'(z));
        chk({tag, " err"},   32'(out_err), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_words;
        int n_errs;
        vecs[0]  = '{8'h01, 0, 1'b0, 1'b0};
        vecs[1]  = '{8'h08, 3, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 7, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 0, 1'b1, 1'b0};
        vecs[4]  = '{8'h0C, 2, 1'b0, 1'b1};
        vecs[5]  = '{8'hFF, 0, 1'b0, 1'b1};
        vecs[6]  = '{8'h02, 1, 1'b0, 1'b0};
        vecs[7]  = '{8'h04, 2, 1'b0, 1'b0};
        vecs[8]  = '{8'h10, 4, 1'b0, 1'b0};
        vecs[9]  = '{8'h20, 5, 1'b0, 1'b0};
        vecs[10] = '{8'h40, 6, 1'b0, 1'b0};
        vecs[11] = '{8'h03, 0, 1'b0, 1'b1};
        vecs[12] = '{8'h60, 5, 1'b0, 1'b1};
        vecs[13] = '{8'hA0, 5, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Reset held three cycles, offering a word that must be ignored.
        in_valid = 1'b1; in_data = 8'h01;
        repeat (3) tick();
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle in_ready", 32'(in_ready), 1);
        chk("idle out_valid", 32'(out_valid), 0);
        chk("idle out_pos", 32'(out_pos), 0);
        chk("idle out_zero", 32'(out_zero), 0);
        chk("idle out_err", 32'(out_err), 0);
        chk("idle stat_words", 32'(stat_words), 0);
        chk("idle stat_errs", 32'(stat_errs), 0);

        // Streaming table with out_ready high: head shows each word one cycle after accept.
        out_ready = 1'b1;
        n_words = 0; n_errs = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 1);
            tick();
            n_words++;
            if (vecs[i].err) n_errs++;
            chk_head($sformatf("vec%0d", i), vecs[i].pos, vecs[i].zero, vecs[i].err);
            if (i == 3) begin
                chk("stream stat_words", 32'(stat_words), 4);
                chk("stream stat_errs", 32'(stat_errs), 0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", 32'(out_valid), 0);
        chk("table stat_words", 32'(stat_words), n_words);
        chk("table stat_errs", 32'(stat_errs), n_errs);

        // Backpressure: third word is refused until a pop frees a slot.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h02;
        tick();
        in_data = 8'h04;
        chk("bp second in_ready", 32'(in_ready), 1);
        tick();
        in_data = 8'h10;
        chk("bp full in_ready", 32'(in_ready), 0);
        chk_head("bp stall0", 1, 1'b0, 1'b0);
        tick();
        tick();
        chk("bp stall in_ready", 32'(in_ready), 0);
        chk_head("bp stall2", 1, 1'b0, 1'b0);
        chk("bp stat_words", 32'(stat_words), n_words + 2);
        out_ready = 1'b1;
        tick();
        chk_head("bp pop1", 2, 1'b0, 1'b0);
        chk("bp reopen in_ready", 32'(in_ready), 1);
        tick();
        chk_head("bp pop2", 4, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("bp drained", 32'(out_valid), 0);
        chk("bp stat_words final", 32'(stat_words), n_words + 3);

        // Accept and pop together at occupancy one keeps a single entry in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        out_ready = 1'b1;
        in_data = 8'h20;
        tick();
        chk_head("occ1 a", 5, 1'b0, 1'b0);
        in_data = 8'h40;
        tick();
        chk_head("occ1 b", 6, 1'b0, 1'b0);
        chk("occ1 in_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        tick();
        chk("occ1 drained", 32'(out_valid), 0);

        // Reset while full discards buffered words and clears counters.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h0C;
        tick();
        in_data = 8'h80;
        tick();
        chk("full before rst", 32'(in_ready), 0);
        rst = 1'b1;
        tick();
        chk("rstfull out_valid", 32'(out_valid), 0);
        chk("rstfull out_pos", 32'(out_pos), 0);
        chk("rstfull out_err", 32'(out_err), 0);
        chk("rstfull in_ready", 32'(in_ready), 0);
        chk("rstfull stat_words", 32'(stat_words), 0);
        chk("rstfull stat_errs", 32'(stat_errs), 0);
        tick();
        chk("rsthold stat_words", 32'(stat_words), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post rst in_ready", 32'(in_ready), 1);
        chk("post rst out_valid", 32'(out_valid), 0);

        // Saturation: five words, four with errors, into 2-bit counters.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h03; tick();
        in_data = 8'h0C; tick();
        in_data = 8'hFF; tick();
        in_data = 8'h60; tick();
        in_data = 8'h01; tick();
        in_valid = 1'b0;
        tick();
        chk("sat stat_words", 32'(s_stat_words), 3);
        chk("sat stat_errs", 32'(s_stat_errs), 3);
        chk("wide stat_words", 32'(stat_words), 5);
        chk("wide stat_errs", 32'(stat_errs), 4);
        chk("sat drained", 32'(s_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
